// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmitter among NREQ
//                byte sources, with optional per-requester lock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  localparam int              IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0]     c_NREQ     = (IW+1)'(NREQ);
  localparam logic [IW-1:0]   c_LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic            r_lock;
  logic [NREQ-1:0] r_grant;
  logic [DBIT-1:0] r_tx_din;
  logic            r_tx_start;

  logic            w_lock_hold;
  logic            w_found;
  logic            w_accept;
  logic [IW-1:0]   w_winner;
  logic [IW:0]     w_sum;
  logic [DBIT-1:0] w_win_data;
  logic [NREQ-1:0] w_ready;

  // Lock only holds while the last owner keeps asserting it; dropping it
  // resumes round-robin in the same cycle.
  assign w_lock_hold = r_lock & req_lock[r_last];

  // Scan offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_sum    = '0;
    if (w_lock_hold) begin
      w_found = req_valid[r_last];
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        w_sum = {1'b0, r_last} + (IW+1)'(k);
        if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
        if (req_valid[w_sum[IW-1:0]]) begin
          w_found  = 1'b1;
          w_winner = w_sum[IW-1:0];
        end
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  always_comb begin
    w_ready    = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IW'(i)) begin
        w_win_data = req_data[DBIT*i +: DBIT];
        w_ready[i] = w_accept;
      end
    end
  end

  assign req_ready = w_ready;
  assign tx_start  = r_tx_start;
  assign tx_din    = r_tx_din;
  assign busy      = (r_state != S_IDLE);
  assign grant     = ((r_state == S_IDLE) && !w_lock_hold) ? '0 : r_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= c_LAST_RST;
      r_lock     <= 1'b0;
      r_grant    <= '0;
      r_tx_din   <= '0;
      r_tx_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!req_lock[r_last]) r_lock <= 1'b0;
          if (w_accept) begin
            r_tx_din   <= w_win_data;
            r_grant    <= w_ready;
            r_last     <= w_winner;
            r_lock     <= req_lock[w_winner];
            r_tx_start <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          r_tx_start <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_tick) r_state <= S_IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic        tx_done_tick;
  wire  [3:0]  req_ready;
  wire         tx_start;
  wire  [7:0]  tx_din;
  wire  [3:0]  grant;
  wire         busy;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the SEND cycle: returns tx_done_tick n cycles later, ends in IDLE.
  task automatic finish_xfer(input int n);
    repeat (n) step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '0; req_data = '0; req_lock = '0; tx_done_tick = 1'b0;
    step(); step();
    checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_din !== 8'h00)   begin errors++; $display("FAIL rst_tx_din: got %h expected 00", tx_din); end
    checks++; if (grant !== 4'b0000)  begin errors++; $display("FAIL rst_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b;
    logic [3:0] exp_r;
    req_valid = 4'b1111;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int j = 0; j < 5; j++) begin
      exp_b = 8'hA0 + 8'(j % 4);
      exp_r = 4'b0001 << (j % 4);
      #1;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", j, req_ready, exp_r); end
      step();
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rr_start[%0d]: got %b expected 1", j, tx_start); end
      checks++; if (tx_din !== exp_b)  begin errors++; $display("FAIL rr_din[%0d]: got %h expected %h", j, tx_din, exp_b); end
      checks++; if (grant !== exp_r)   begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", j, grant, exp_r); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL rr_busy[%0d]: got %b expected 1", j, busy); end
      step();
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rr_wait_start[%0d]: got %b expected 0", j, tx_start); end
      checks++; if (tx_din !== exp_b)  begin errors++; $display("FAIL rr_wait_din[%0d]: got %h expected %h", j, tx_din, exp_b); end
      finish_xfer(9);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rr_idle_busy[%0d]: got %b expected 0", j, busy); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_idle_grant[%0d]: got %b expected 0000", j, grant); end
    end
    req_valid = '0;
  endtask

  task automatic test_lock_burst();
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    req_valid = 4'b1011;
    req_lock  = 4'b0010;
    req_data  = {8'h30, 8'h00, 8'h11, 8'h0F};
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected 0010", j, req_ready); end
      if (j > 0) begin
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL lock_idle_grant[%0d]: got %b expected 0010", j, grant); end
      end
      step();
      checks++; if (tx_din !== bytes[j]) begin errors++; $display("FAIL lock_din[%0d]: got %h expected %h", j, tx_din, bytes[j]); end
      step();
      if (j < 2) req_data[15:8] = bytes[j+1];
      else begin req_valid = 4'b1001; req_lock = 4'b0000; end
      #1;
      checks++; if (tx_din !== bytes[j]) begin errors++; $display("FAIL lock_hold_din[%0d]: got %h expected %h", j, tx_din, bytes[j]); end
      finish_xfer(2);
    end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL unlock_ready3: got %b expected 1000", req_ready); end
    checks++; if (grant !== 4'b0000)     begin errors++; $display("FAIL unlock_grant: got %b expected 0000", grant); end
    step();
    checks++; if (tx_din !== 8'h30)      begin errors++; $display("FAIL unlock_din3: got %h expected 30", tx_din); end
    finish_xfer(3);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL unlock_ready0: got %b expected 0001", req_ready); end
    step();
    checks++; if (tx_din !== 8'h0F)      begin errors++; $display("FAIL unlock_din0: got %h expected 0F", tx_din); end
    finish_xfer(3);
    req_valid = '0;
  endtask

  task automatic test_lock_wait();
    int bad;
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    req_data  = {8'h00, 8'h00, 8'h44, 8'h5A};
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lw_ready1: got %b expected 0010", req_ready); end
    step();
    checks++; if (tx_din !== 8'h44) begin errors++; $display("FAIL lw_din1: got %h expected 44", tx_din); end
    step();
    req_valid = 4'b0001;
    finish_xfer(3);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready !== 4'b0000 || grant !== 4'b0010 || busy !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lw_hold: got %0d bad cycles expected 0 (ready %b grant %b)", bad, req_ready, grant); end
    req_lock = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lw_release_ready: got %b expected 0001", req_ready); end
    checks++; if (grant !== 4'b0000)     begin errors++; $display("FAIL lw_release_grant: got %b expected 0000", grant); end
    step();
    checks++; if (tx_din !== 8'h5A || grant !== 4'b0001) begin errors++; $display("FAIL lw_serve0: got din %h grant %b expected 5A 0001", tx_din, grant); end
    finish_xfer(3);
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h55, 8'h00, 8'h00};
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || tx_din !== 8'h55) begin errors++; $display("FAIL single_start: got start %b din %h expected 1 55", tx_start, tx_din); end
    step();
    req_data  = 32'hFFFF_FFFF;
    req_valid = 4'b1111;
    #1;
    checks++; if (tx_din !== 8'h55)      begin errors++; $display("FAIL single_hold_din: got %h expected 55", tx_din); end
    checks++; if (grant !== 4'b0100)     begin errors++; $display("FAIL single_grant: got %b expected 0100", grant); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_wait_ready: got %b expected 0000", req_ready); end
    req_valid = 4'b0000;
    repeat (4) step();
    tx_done_tick = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_tick: got %b expected 1", busy); end
    step();
    tx_done_tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_done_in_send();
    req_valid = 4'b0001;
    req_data  = {8'h00, 8'h00, 8'h00, 8'h3C};
    step();
    req_valid = 4'b0000;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin errors++; $display("FAIL send_tick_ignored: got busy %b start %b expected 1 0", busy, tx_start); end
    repeat (5) step();
    checks++; if (busy !== 1'b1 || tx_din !== 8'h3C) begin errors++; $display("FAIL send_tick_wait: got busy %b din %h expected 1 3C", busy, tx_din); end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL send_tick_late: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    req_valid = 4'b0010;
    req_data  = {8'hD3, 8'hC2, 8'h77, 8'hB0};
    step();
    reset = 1'b0;
    req_valid = 4'b0000;
    step();
    checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_send: got start %b busy %b expected 0 0", tx_start, busy); end
    reset = 1'b1;
    req_valid = 4'b0100;
    step();
    step();
    reset = 1'b0;
    req_valid = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (tx_din !== 8'h00)  begin errors++; $display("FAIL abort_din: got %h expected 00", tx_din); end
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_rr_restart: got %b expected 0001", req_ready); end
    step();
    checks++; if (tx_din !== 8'hB0) begin errors++; $display("FAIL abort_next_din: got %h expected B0", tx_din); end
    req_valid = 4'b0000;
    finish_xfer(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_burst();
    test_lock_wait();
    test_single();
    test_done_in_send();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL provide parameter NREQ, default 4, number of requesters.
REQ-002 The block SHALL provide parameter DBIT, default 8, data bits per character.
REQ-003 The block SHALL provide clk  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL provide reset  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
REQ-005 The block SHALL provide req_valid  input  NREQ  per-requester byte available.
REQ-006 The block SHALL provide req_data  input  NREQ*DBIT  packed bytes; requester i at [DBIT*i+DBIT-1 : DBIT*i].
REQ-007 The block SHALL provide req_lock  input  NREQ  per-requester request to hold the transmitter across consecutive bytes.
REQ-008 The block SHALL provide req_ready  output  NREQ  accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both 1.
REQ-009 The block SHALL provide tx_start  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-010 The block SHALL provide tx_din  output  DBIT  byte presented to the transmitter, stable from tx_start until tx_done_tick.
REQ-011 The block SHALL provide tx_done_tick  input  1  transmitter completion pulse.
REQ-012 The block SHALL provide grant  output  NREQ  one-hot owner of the transmitter, or all zero when none.
REQ-013 The block SHALL provide busy  output  1  high in SEND and WAIT.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT.
REQ-015 In IDLE, when unlocked, the winner SHALL be the first requester with req_valid=1 searching from (last+1) mod NREQ upward with wrap-around; last = most recently served index.
REQ-016 In IDLE, req_ready SHALL be combinational: 1 only at the winner bit, 0 elsewhere; all zero when no req_valid is set.
REQ-017 On an accept edge the block SHALL latch the winner's byte into tx_din, set grant to the winner, set last to the winner and go to SEND.
REQ-018 SEND SHALL last exactly one cycle with tx_start=1, then go to WAIT; tx_start SHALL be 0 in every other state.
REQ-019 In WAIT the block SHALL hold tx_din and grant; on tx_done_tick=1 it SHALL go to IDLE.
REQ-020 tx_done_tick SHALL be ignored in IDLE and SEND.
REQ-021 Latency: req_valid seen in IDLE at cycle n -> accept at edge n -> tx_start high in cycle n+1 -> WAIT from cycle n+2.
REQ-022 Minimum gap: after tx_done_tick in cycle m, the next accept SHALL occur no earlier than cycle m+1 (IDLE).
REQ-023 Lock: if req_lock[last]=1 at an accept edge, the lock flag SHALL set; while set, IDLE SHALL consider only requester last and SHALL wait if its req_valid=0.
REQ-024 The lock flag SHALL clear in IDLE on any cycle where req_lock[last]=0; normal round-robin SHALL resume in that same cycle.
REQ-025 grant SHALL be retained in IDLE while locked and SHALL be zero in IDLE while unlocked.
REQ-026 A requester that drops req_valid before being accepted SHALL lose nothing; no request is stored internally.
REQ-027 Changes on req_data and req_valid during SEND and WAIT SHALL not affect tx_din.

Reset
REQ-028 With reset=0 at a rising edge: state IDLE, tx_start 0, tx_din 0, grant 0, busy 0, lock flag 0, last=NREQ-1 (requester 0 highest priority first).
REQ-029 Reset asserted during SEND or WAIT SHALL abort the transfer; tx_start SHALL be 0 in the cycle after the reset edge, and the pending byte SHALL be discarded.

Verification
REQ-030 After reset, req_valid=4'b1111 with byte i = 8'hA0+i, tx_done_tick returned 10 cycles after each tx_start -> tx_din order A0,A1,A2,A3,A0; exactly one req_ready bit set per accept.
REQ-031 Only requester 2 valid with 8'h55 -> req_ready=4'b0100 in the same cycle, tx_start=1 the next cycle with tx_din=8'h55, busy=1 until the cycle after tx_done_tick.
REQ-032 Requester 1 sets req_lock with 3 bytes 11,22,33 while requesters 0 and 3 are valid -> 11,22,33 sent back to back; then requester 1 drops lock -> next grant is 3, then 0.
REQ-033 Locked requester 1 with req_valid=0 for 20 cycles while 0 is valid -> no accept, grant=4'b0010 held; releasing the lock -> requester 2 considered first, requester 0 served.
REQ-034 tx_done_tick pulsed in the SEND cycle -> ignored; block stays in WAIT until a later tick.
REQ-035 reset=0 during WAIT -> grant 0, busy 0, tx_din 0 next cycle; next round-robin search starts at requester 0.
